// File: rtl/cp0_pkg.sv
// Shared constants and types for the coprocessor-0 controller.
package cp0_pkg;

  // CP0 register indices
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_DIV0 = 5'd7;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_NONE = 5'd31;

  // Status / Cause field positions
  localparam int STATUS_IE     = 0;
  localparam int STATUS_KSU_LO = 3;
  localparam int STATUS_IM_LO  = 8;
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_IP_LO   = 8;
  // Timer interrupt position inside the 8-bit IP/IM field (Cause/Status bit 15)
  localparam int IP_TIMER_BIT  = 7;

  // One saved context: 35 bits
  typedef struct packed {
    logic [1:0]  ksu;
    logic        ie;
    logic [31:0] epc;
  } ctx_t;

endpackage

// File: rtl/cp0_ctx_stack.sv
// Saved-context LIFO; a push while full overwrites the top entry.
module cp0_ctx_stack
  import cp0_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  ctx_t          push_data,
  output ctx_t          top_data,
  output logic [LW-1:0] level
);

  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [LW-1:0]    level_reg;
  ctx_t             mem_reg [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic             full;

  assign full  = (level_reg == FULL);
  assign level = level_reg;

  // Slot select: next free slot, or the top slot once full
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr
      assign wr_en[gi] = push && (full ? (gi == DEPTH - 1) : (level_reg == LW'(gi)));
    end
  endgenerate

  // Entry storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= push_data;
      end
    end
  end

  // Occupancy: saturates at DEPTH, never goes below zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_reg <= '0;
    end else if (push && !full) begin
      level_reg <= level_reg + 1'b1;
    end else if (pop && (level_reg != '0)) begin
      level_reg <= level_reg - 1'b1;
    end
  end

  // Top-of-stack read, zero when empty
  always_comb begin
    top_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (level_reg == LW'(i + 1)) top_data = mem_reg[i];
    end
  end

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 controller: exception/interrupt entry, ERET, timer, PC redirect.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int          INT_NUM      = 6,
  parameter int          NEST_DEPTH   = 2,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000F500,
  parameter int          CNT_EN       = 1,
  localparam int         NL_W         = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               commit_valid,
  input  logic               overflow,
  input  logic               divide_zero,
  input  logic               reserved_instruction,
  input  logic               break_i,
  input  logic               syscall,
  input  logic               eret,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic [31:0]        pc,
  input  logic [4:0]         rd,
  input  logic [31:0]        rt_value,
  input  logic [INT_NUM-1:0] ext_int,
  output logic [31:0]        cp0_data_out,
  output logic               cp0_wen,
  output logic [31:0]        redirect_pc,
  output logic [4:0]         exc_code,
  output logic [NL_W-1:0]    nest_level
);

  logic               ie_reg, ie_next;
  logic [1:0]         ksu_reg, ksu_next;
  logic [7:0]         im_reg, im_next;
  logic [4:0]         exc_field_reg, exc_field_next;
  logic [31:0]        epc_reg, epc_next;
  logic [31:0]        count_reg, count_next;
  logic [31:0]        compare_reg, compare_next;
  logic               pend_reg, pend_next;
  logic [INT_NUM-1:0] ext_reg;
  logic               wen_reg, wen_next;
  logic [31:0]        rpc_reg, rpc_next;
  logic [4:0]         code_reg, code_next;

  logic [7:0]         ip_vec;
  logic               sync_exc, int_take, take, do_eret, do_mtc0;
  logic               stack_full, stack_empty;
  logic [4:0]         evt_code;
  ctx_t               top_ctx, push_ctx;
  logic [NL_W-1:0]    level;

  // mfc0 is a pure read and has no effect on state
  logic unused_mfc0;
  assign unused_mfc0 = mfc0;

  cp0_ctx_stack #(
    .DEPTH (NEST_DEPTH),
    .LW    (NL_W)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (take),
    .pop       (do_eret && !stack_empty),
    .push_data (push_ctx),
    .top_data  (top_ctx),
    .level     (level)
  );

  assign push_ctx    = '{ksu: ksu_reg, ie: ie_reg, epc: epc_reg};
  assign stack_full  = (level == NL_W'(NEST_DEPTH));
  assign stack_empty = (level == '0);

  // Pending-interrupt vector: sampled lines plus the sticky timer bit
  always_comb begin
    ip_vec                  = '0;
    ip_vec[INT_NUM-1:0]     = ext_reg;
    ip_vec[IP_TIMER_BIT]    = pend_reg;
  end

  assign sync_exc = commit_valid &&
                    (syscall || divide_zero || break_i || reserved_instruction || overflow);
  // Interrupts never overwrite a saved context: they wait for stack room
  assign int_take = commit_valid && ie_reg && (|(ip_vec & im_reg)) && !stack_full;
  assign take     = sync_exc || int_take;
  assign do_eret  = commit_valid && eret && !take;
  assign do_mtc0  = commit_valid && mtc0 && !take;

  // Fixed event priority
  always_comb begin
    evt_code = EXC_NONE;
    if (syscall)                   evt_code = EXC_SYS;
    else if (divide_zero)          evt_code = EXC_DIV0;
    else if (break_i)              evt_code = EXC_BP;
    else if (reserved_instruction) evt_code = EXC_RI;
    else if (overflow)             evt_code = EXC_OV;
    else if (int_take)             evt_code = EXC_INT;
  end

  // Next state: mtc0 applies first, then entry or ERET overrides the fields they own
  always_comb begin
    ie_next        = ie_reg;
    ksu_next       = ksu_reg;
    im_next        = im_reg;
    exc_field_next = exc_field_reg;
    epc_next       = epc_reg;
    compare_next   = compare_reg;
    pend_next      = pend_reg;
    count_next     = (CNT_EN != 0) ? count_reg + 32'd1 : 32'd0;
    wen_next       = 1'b0;
    rpc_next       = rpc_reg;
    code_next      = code_reg;

    if ((CNT_EN != 0) && (count_reg == compare_reg) && (compare_reg != 32'd0))
      pend_next = 1'b1;

    if (do_mtc0) begin
      case (rd)
        CP0_COUNT:   if (CNT_EN != 0) count_next = rt_value;
        CP0_COMPARE: begin
          compare_next = rt_value;
          pend_next    = 1'b0;
        end
        CP0_STATUS: begin
          ie_next  = rt_value[STATUS_IE];
          ksu_next = rt_value[STATUS_KSU_LO +: 2];
          im_next  = rt_value[STATUS_IM_LO +: 8];
        end
        CP0_CAUSE:   exc_field_next = rt_value[CAUSE_EXC_LO +: 5];
        CP0_EPC:     epc_next = rt_value;
        default: ;
      endcase
    end

    if (take) begin
      ie_next        = 1'b0;
      ksu_next       = 2'b00;
      exc_field_next = evt_code;
      epc_next       = pc;
      code_next      = evt_code;
      wen_next       = 1'b1;
      rpc_next       = HANDLER_ADDR;
    end else if (do_eret) begin
      wen_next = 1'b1;
      rpc_next = epc_reg;
      if (!stack_empty) begin
        ksu_next = top_ctx.ksu;
        ie_next  = top_ctx.ie;
        epc_next = top_ctx.epc;
      end else begin
        ie_next = 1'b1;
      end
    end
  end

  // State registers, including the registered redirect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ie_reg        <= 1'b0;
      ksu_reg       <= 2'b00;
      im_reg        <= '0;
      exc_field_reg <= '0;
      epc_reg       <= '0;
      count_reg     <= '0;
      compare_reg   <= '0;
      pend_reg      <= 1'b0;
      ext_reg       <= '0;
      wen_reg       <= 1'b0;
      rpc_reg       <= '0;
      code_reg      <= EXC_NONE;
    end else begin
      ie_reg        <= ie_next;
      ksu_reg       <= ksu_next;
      im_reg        <= im_next;
      exc_field_reg <= exc_field_next;
      epc_reg       <= epc_next;
      count_reg     <= count_next;
      compare_reg   <= compare_next;
      pend_reg      <= pend_next;
      ext_reg       <= ext_int;
      wen_reg       <= wen_next;
      rpc_reg       <= rpc_next;
      code_reg      <= code_next;
    end
  end

  // Combinational register read; unimplemented indices return zero
  always_comb begin
    cp0_data_out = '0;
    case (rd)
      CP0_COUNT:   cp0_data_out = count_reg;
      CP0_COMPARE: cp0_data_out = compare_reg;
      CP0_STATUS: begin
        cp0_data_out[STATUS_IE]          = ie_reg;
        cp0_data_out[STATUS_KSU_LO +: 2] = ksu_reg;
        cp0_data_out[STATUS_IM_LO +: 8]  = im_reg;
      end
      CP0_CAUSE: begin
        cp0_data_out[CAUSE_EXC_LO +: 5] = exc_field_reg;
        cp0_data_out[CAUSE_IP_LO +: 8]  = ip_vec;
      end
      CP0_EPC:     cp0_data_out = epc_reg;
      default: ;
    endcase
  end

  assign cp0_wen     = wen_reg;
  assign redirect_pc = rpc_reg;
  assign exc_code    = code_reg;
  assign nest_level  = level;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios then random commits vs. a reference model.
module tb_cp0_ctrl;

  localparam int          INT_NUM    = 6;
  localparam int          NEST_DEPTH = 2;
  localparam int          NL_W       = $clog2(NEST_DEPTH + 1);
  localparam logic [31:0] HANDLER    = 32'h0000F500;

  localparam logic [7:0] F_MTC0 = 8'h01, F_MFC0 = 8'h02, F_ERET = 8'h04, F_SYS = 8'h08;
  localparam logic [7:0] F_BRK  = 8'h10, F_RI   = 8'h20, F_DIV  = 8'h40, F_OV  = 8'h80;

  logic               clock = 1'b0;
  logic               reset;
  logic               commit_valid, overflow, divide_zero, reserved_instruction;
  logic               break_i, syscall, eret, mfc0, mtc0;
  logic [31:0]        pc, rt_value;
  logic [4:0]         rd;
  logic [INT_NUM-1:0] ext_int;
  logic [31:0]        cp0_data_out, redirect_pc;
  logic               cp0_wen;
  logic [4:0]         exc_code;
  logic [NL_W-1:0]    nest_level;

  always #5 clock = ~clock;

  cp0_ctrl #(
    .INT_NUM      (INT_NUM),
    .NEST_DEPTH   (NEST_DEPTH),
    .HANDLER_ADDR (HANDLER),
    .CNT_EN       (1)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .commit_valid         (commit_valid),
    .overflow             (overflow),
    .divide_zero          (divide_zero),
    .reserved_instruction (reserved_instruction),
    .break_i              (break_i),
    .syscall              (syscall),
    .eret                 (eret),
    .mfc0                 (mfc0),
    .mtc0                 (mtc0),
    .pc                   (pc),
    .rd                   (rd),
    .rt_value             (rt_value),
    .ext_int              (ext_int),
    .cp0_data_out         (cp0_data_out),
    .cp0_wen              (cp0_wen),
    .redirect_pc          (redirect_pc),
    .exc_code             (exc_code),
    .nest_level           (nest_level)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit [1:0]  ksu;
    bit        ie;
    bit [31:0] epc;
  } saved_t;

  bit               m_ie;
  bit [1:0]         m_ksu;
  bit [7:0]         m_im;
  bit [4:0]         m_excf;
  bit [31:0]        m_epc, m_count, m_compare;
  bit               m_pend;
  bit [INT_NUM-1:0] m_ext;
  saved_t           m_stack[$];
  bit               m_wen;
  bit [31:0]        m_rpc;
  bit [4:0]         m_code;

  task automatic model_reset();
    m_ie = 0; m_ksu = 0; m_im = 0; m_excf = 0; m_epc = 0;
    m_count = 0; m_compare = 0; m_pend = 0; m_ext = 0;
    m_stack.delete();
    m_wen = 0; m_rpc = 0; m_code = 5'd31;
  endtask

  function automatic bit [7:0] model_ip();
    bit [7:0] ip;
    ip = 8'h00;
    ip[INT_NUM-1:0] = m_ext;
    ip[7] = m_pend;
    return ip;
  endfunction

  function automatic bit [31:0] model_read(input logic [4:0] r);
    case (r)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return {16'h0, m_im, 3'b000, m_ksu, 2'b00, m_ie};
      5'd13:   return {16'h0, model_ip(), 1'b0, m_excf, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the architectural rules, using the inputs present at the edge
  task automatic model_step();
    bit [31:0] old_epc, old_count, old_compare;
    bit [4:0]  code;
    bit        take, int_ok;
    saved_t    s;
    old_epc = m_epc; old_count = m_count; old_compare = m_compare;
    int_ok = m_ie && ((model_ip() & m_im) != 0) && (m_stack.size() < NEST_DEPTH);
    take = 1; code = 0;
    if (!commit_valid)             take = 0;
    else if (syscall)              code = 8;
    else if (divide_zero)          code = 7;
    else if (break_i)              code = 9;
    else if (reserved_instruction) code = 10;
    else if (overflow)             code = 12;
    else if (int_ok)               code = 0;
    else                           take = 0;

    m_wen = 0;
    m_count = old_count + 1;
    if (old_count == old_compare && old_compare != 0) m_pend = 1;

    if (take) begin
      s.ksu = m_ksu; s.ie = m_ie; s.epc = m_epc;
      if (m_stack.size() < NEST_DEPTH) m_stack.push_back(s);
      else m_stack[m_stack.size() - 1] = s;
      m_ie = 0; m_ksu = 0; m_excf = code; m_epc = pc;
      m_code = code; m_wen = 1; m_rpc = HANDLER;
    end else if (commit_valid) begin
      if (mtc0) begin
        case (rd)
          5'd9:  m_count = rt_value;
          5'd11: begin m_compare = rt_value; m_pend = 0; end
          5'd12: begin m_ie = rt_value[0]; m_ksu = rt_value[4:3]; m_im = rt_value[15:8]; end
          5'd13: m_excf = rt_value[6:2];
          5'd14: m_epc = rt_value;
          default: ;
        endcase
      end
      if (eret) begin
        m_wen = 1;
        m_rpc = old_epc;
        if (m_stack.size() > 0) begin
          s = m_stack.pop_back();
          m_ksu = s.ksu; m_ie = s.ie; m_epc = s.epc;
        end else begin
          m_ie = 1;
        end
      end
    end
    m_ext = ext_int;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    commit_valid = 0; overflow = 0; divide_zero = 0; reserved_instruction = 0;
    break_i = 0; syscall = 0; eret = 0; mfc0 = 0; mtc0 = 0;
    pc = 32'h0; rd = 5'd0; rt_value = 32'h0;
  endtask

  // Compare the combinational read, clock once, then compare the registered outputs
  task automatic tick(input string tag);
    #1;
    check({tag, ":rdata"}, cp0_data_out, model_read(rd));
    @(posedge clock);
    model_step();
    #1;
    check({tag, ":wen"},   {31'h0, cp0_wen}, {31'h0, m_wen});
    check({tag, ":rpc"},   redirect_pc, m_rpc);
    check({tag, ":code"},  {27'h0, exc_code}, {27'h0, m_code});
    check({tag, ":level"}, 32'(nest_level), 32'(m_stack.size()));
  endtask

  task automatic commit(input logic [7:0] f, input logic [31:0] p, input logic [4:0] r,
                        input logic [31:0] v, input string tag);
    commit_valid = 1;
    mtc0 = f[0]; mfc0 = f[1]; eret = f[2]; syscall = f[3];
    break_i = f[4]; reserved_instruction = f[5]; divide_zero = f[6]; overflow = f[7];
    pc = p; rd = r; rt_value = v;
    tick(tag);
    set_idle();
  endtask

  task automatic peek(input logic [4:0] r, input logic [31:0] exp, input string tag);
    rd = r;
    #1;
    check(tag, cp0_data_out, exp);
  endtask

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  logic [4:0] rd_tab [6];
  bit         seen;
  int         n;

  initial begin
    rd_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    set_idle();
    ext_int = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    // Reset state
    check("rst_wen",   {31'h0, cp0_wen}, 32'h0);
    check("rst_rpc",   redirect_pc, 32'h0);
    check("rst_code",  {27'h0, exc_code}, 32'h1F);
    check("rst_level", 32'(nest_level), 32'h0);
    peek(5'd12, 32'h0, "rst_status");
    peek(5'd13, 32'h0, "rst_cause");
    peek(5'd9,  32'h0, "rst_count");
    reset = 1'b1;

    // 1: masked external interrupt
    commit(F_MTC0, 32'h0, 5'd12, 32'h0000_0401, "t1_status");
    ext_int = 6'b000100;
    tick("t1_sample");
    commit(8'h00, 32'h100, 5'd0, 32'h0, "t1_int");
    check("t1_wen",   {31'h0, cp0_wen}, 32'h1);
    check("t1_rpc",   redirect_pc, 32'hF500);
    check("t1_code",  {27'h0, exc_code}, 32'h0);
    check("t1_level", 32'(nest_level), 32'h1);
    peek(5'd14, 32'h100, "t1_epc");
    peek(5'd12, 32'h400, "t1_status_ie0");
    peek(5'd13, 32'h400, "t1_cause");
    ext_int = '0;
    tick("t1_clr");
    commit(F_ERET, 32'h104, 5'd0, 32'h0, "t1_eret");
    check("t1_eret_rpc",   redirect_pc, 32'h100);
    check("t1_eret_level", 32'(nest_level), 32'h0);
    peek(5'd12, 32'h401, "t1_status_restored");

    // 2: syscall with IE=0, then ERET
    commit(F_MTC0, 32'h0, 5'd12, 32'h0, "t2_status");
    commit(F_SYS, 32'h200, 5'd0, 32'h0, "t2_sys");
    check("t2_code", {27'h0, exc_code}, 32'h8);
    peek(5'd14, 32'h200, "t2_epc");
    commit(F_ERET, 32'h204, 5'd0, 32'h0, "t2_eret");
    check("t2_rpc",   redirect_pc, 32'h200);
    check("t2_level", 32'(nest_level), 32'h0);
    peek(5'd12, 32'h0, "t2_ie");

    // 3: syscall+overflow+mtc0 in one commit
    commit(F_SYS | F_OV | F_MTC0, 32'h300, 5'd12, 32'hFFFF_FFFF, "t3_multi");
    check("t3_code", {27'h0, exc_code}, 32'h8);
    check("t3_wen",  {31'h0, cp0_wen}, 32'h1);
    tick("t3_after");
    check("t3_single_pulse", {31'h0, cp0_wen}, 32'h0);
    peek(5'd12, 32'h0, "t3_status_kept");
    commit(F_ERET, 32'h304, 5'd0, 32'h0, "t3_eret");

    // 4: nesting beyond the stack depth
    commit(F_SYS, 32'h10, 5'd0, 32'h0, "t4_s1");
    check("t4_l1", 32'(nest_level), 32'h1);
    commit(F_SYS, 32'h20, 5'd0, 32'h0, "t4_s2");
    check("t4_l2", 32'(nest_level), 32'h2);
    commit(F_SYS, 32'h30, 5'd0, 32'h0, "t4_s3");
    check("t4_l3", 32'(nest_level), 32'h2);
    commit(F_ERET, 32'h0, 5'd0, 32'h0, "t4_e1");
    check("t4_e1_rpc", redirect_pc, 32'h30);
    commit(F_ERET, 32'h0, 5'd0, 32'h0, "t4_e2");
    check("t4_e2_rpc", redirect_pc, 32'h20);
    check("t4_final_level", 32'(nest_level), 32'h0);

    // 5: Count/Compare timer interrupt
    commit(F_MTC0, 32'h0, 5'd11, 32'd20, "t5_cmp");
    commit(F_MTC0, 32'h0, 5'd9, 32'd0, "t5_cnt");
    commit(F_MTC0, 32'h0, 5'd12, 32'h0000_8001, "t5_status");
    commit_valid = 1; pc = 32'h500;
    seen = 0; n = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick("t5_wait");
      n = k + 1;
      if (cp0_wen) seen = 1;
    end
    set_idle();
    check("t5_timer_seen", {31'h0, seen}, 32'h1);
    check("t5_delay_ok", {31'h0, (n >= 18 && n <= 24)}, 32'h1);
    check("t5_code", {27'h0, exc_code}, 32'h0);
    peek(5'd13, 32'h8000, "t5_ip15_set");
    commit(F_MTC0, 32'h0, 5'd11, 32'h0, "t5_cmp_clr");
    peek(5'd13, 32'h0, "t5_ip15_clr");

    // 6: reset between an exception edge and the redirect pulse
    commit(F_BRK, 32'h600, 5'd0, 32'h0, "t6_brk");
    #2 reset = 1'b0;
    #1;
    check("t6_wen",   {31'h0, cp0_wen}, 32'h0);
    check("t6_rpc",   redirect_pc, 32'h0);
    check("t6_code",  {27'h0, exc_code}, 32'h1F);
    check("t6_level", 32'(nest_level), 32'h0);
    peek(5'd14, 32'h0, "t6_epc");
    peek(5'd12, 32'h0, "t6_status");
    peek(5'd11, 32'h0, "t6_compare");
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;

    // Random commits against the model
    for (int i = 0; i < 400; i++) begin
      commit_valid         = ($urandom_range(0, 3) != 0);
      syscall              = ($urandom_range(0, 15) == 0);
      divide_zero          = ($urandom_range(0, 15) == 0);
      break_i              = ($urandom_range(0, 15) == 0);
      reserved_instruction = ($urandom_range(0, 15) == 0);
      overflow             = ($urandom_range(0, 15) == 0);
      eret                 = ($urandom_range(0, 5) == 0);
      mtc0                 = ($urandom_range(0, 3) == 0);
      mfc0                 = ($urandom_range(0, 3) == 0);
      rd                   = rd_tab[$urandom_range(0, 5)];
      rt_value             = $urandom;
      pc                   = $urandom;
      if ($urandom_range(0, 3) == 0) ext_int = INT_NUM'($urandom);
      tick("rnd");
    end
    set_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
